char_buf_ram: RTL and testbench
===============================

CHAR_BUF_RAM -- requirements
Module: char_buf_ram

Interface
REQ-001 The module SHALL have parameter COLS, default 16, meaning number of character columns (1..256).
REQ-002 The module SHALL have parameter ROWS, default 16, meaning number of character rows (1..256).
REQ-003 The module SHALL have parameter CODE_W, default 7, meaning character code width in bits.
REQ-004 The module SHALL derive XW = clog2(COLS) and YW = clog2(ROWS), each with a minimum of 1; all yx buses SHALL be {y[YW-1:0], x[XW-1:0]}.
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- char_yx  in  YW+XW  read address.
- char_code  out  CODE_W  registered read data.
- wr_en  in  1  random-access write request.
- wr_yx  in  YW+XW  write address.
- wr_code  in  CODE_W  write data.
- put_en  in  1  cursor-stream write request.
- put_code  in  CODE_W  stream write data.
- cur_set  in  1  load cursor from wr_yx.
- cur_yx  out  YW+XW  current cursor position.
- fill_start  in  1  start whole-buffer fill.
- fill_code  in  CODE_W  fill value, sampled on accepted fill_start.
- busy  out  1  fill in progress; writes blocked.
- fill_done  out  1  one-cycle pulse at the end of a fill.

Function
REQ-006 The read path SHALL return the contents of char_yx on char_code exactly 1 cycle after the address is presented.
REQ-007 Reads with x >= COLS or y >= ROWS SHALL return 0.
REQ-008 A read and a write to the same cell in the same cycle SHALL return the old contents (read-first).
REQ-009 A wr_en with busy=0 and an in-range wr_yx SHALL write wr_code into that cell at the clock edge; out-of-range writes SHALL be dropped.
REQ-010 A put_en with busy=0 SHALL write put_code at cur_yx, then advance the cursor row-major:
- x+1 normally.
- x=COLS-1: x wraps to 0 and y increments.
- Last cell: the cursor wraps to (0,0).
REQ-011 Write priority in one cycle SHALL be: fill engine > wr_en > put_en; the losing put_en SHALL NOT advance the cursor.
REQ-012 cur_set with busy=0 SHALL load the cursor from wr_yx, clamped to (0,0) if out of range; cur_set SHALL take priority over a same-cycle put_en advance, and that put_en SHALL write at the old cursor.
REQ-013 The fill FSM SHALL have three states: IDLE, FILL, DONE.
- IDLE -> FILL on fill_start, latching fill_code and zeroing the sweep counter.
- FILL writes one cell per cycle row-major, COLS*ROWS cycles total.
- FILL -> DONE after the last cell is written.
- DONE -> IDLE unconditionally.
REQ-014 busy SHALL be 1 in the FILL state only; fill_done SHALL be 1 in the DONE state only (a one-cycle pulse).
REQ-015 fill_start while busy=1 or in DONE SHALL be ignored.
REQ-016 wr_en, put_en and cur_set while busy=1 SHALL be ignored; the cursor SHALL be unchanged by a fill.
REQ-017 A wr_en asserted in the same cycle as an accepted fill_start (IDLE) SHALL be performed, and then overwritten by the sweep.
REQ-018 Reads SHALL remain available during a fill, returning the pre- or post-fill value per cell depending on sweep progress.

Reset
REQ-019 While rst=1, the outputs SHALL be:
- char_code = 0.
- cur_yx = 0.
- fill_done = 0.
- busy = 0.
REQ-020 The storage array SHALL NOT be reset directly; on rst deassertion the FSM SHALL enter FILL with fill value 0, so the buffer is cleared in COLS*ROWS cycles (busy=1 from the first edge after release).
REQ-021 rst asserted mid-fill SHALL abort the sweep immediately; the post-release auto-clear then restarts from cell (0,0).

Structure
REQ-022 Package char_buf_pkg SHALL hold the fill state enumeration and the default COLS/ROWS/CODE_W constants.
REQ-023 The sweep FSM and counter SHALL be a sub-module char_buf_fill, exposing a write-enable/address/data triple to the array; the storage SHALL infer block or distributed RAM (no reset on the array).

Verification
REQ-024 Reset release: busy=1 for exactly 256 cycles (16x16), then fill_done=1 for 1 cycle; reads of all 256 cells SHALL return 0.
REQ-025 After wr_en to yx=8'h2a with code 67, reading 8'h2a SHALL give 67 one cycle later; a same-cycle read SHALL give 0 (old value).
REQ-026 cur_set to 8'h0f, then three put_en with codes 65, 66, 67 SHALL write 8'h0f=65, 8'h10=66, 8'h11=67 and leave cur_yx=8'h12; put_en at 8'hff SHALL wrap cur_yx to 8'h00.
REQ-027 fill_start with fill_code=95 SHALL make all cells read 95; wr_en and put_en issued during busy SHALL leave no trace and cur_yx unchanged; a second fill_start during busy SHALL NOT extend the 256-cycle busy window.
REQ-028 With COLS=10, ROWS=3: a read of x=12 SHALL return 0, a write to x=12 SHALL be dropped, put_en at (9,2) SHALL wrap the cursor to (0,0), and the fill SHALL take 30 cycles.
REQ-029 rst pulse at sweep cell 100 SHALL cause busy to be reasserted after release and a full 256-cycle clear restarting from cell 0.

Source files
------------

// File: rtl/char_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : char_buf_pkg
// Description : Shared types and defaults for the character buffer RAM:
//               fill-engine state encoding, default geometry and code width,
//               and an address-width helper (clog2 with a minimum of 1).
// Revision    : 1.0 - initial release
// ============================================================================
package char_buf_pkg;

  localparam int c_def_cols   = 16;
  localparam int c_def_rows   = 16;
  localparam int c_def_code_w = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } fill_state_t;

  // Coordinate width for a dimension of n entries; never narrower than 1 bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/char_buf_ram_if.sv
`default_nettype none
// ============================================================================
// Module      : char_buf_ram_if
// Description : Bus bundle for char_buf_ram. All yx buses are {y, x}.
//   master : drives char_yx, wr_en/wr_yx/wr_code, put_en/put_code, cur_set,
//            fill_start/fill_code; observes char_code, cur_yx, busy, fill_done
//   slave  : the buffer itself (opposite directions)
// Revision    : 1.0 - initial release
// ============================================================================
interface char_buf_ram_if #(
  parameter int XW     = 4,
  parameter int YW     = 4,
  parameter int CODE_W = 7
);
  logic [YW+XW-1:0]  char_yx;
  logic [CODE_W-1:0] char_code;
  logic              wr_en;
  logic [YW+XW-1:0]  wr_yx;
  logic [CODE_W-1:0] wr_code;
  logic              put_en;
  logic [CODE_W-1:0] put_code;
  logic              cur_set;
  logic [YW+XW-1:0]  cur_yx;
  logic              fill_start;
  logic [CODE_W-1:0] fill_code;
  logic              busy;
  logic              fill_done;

  modport master (
    output char_yx, wr_en, wr_yx, wr_code, put_en, put_code, cur_set,
           fill_start, fill_code,
    input  char_code, cur_yx, busy, fill_done
  );

  modport slave (
    input  char_yx, wr_en, wr_yx, wr_code, put_en, put_code, cur_set,
           fill_start, fill_code,
    output char_code, cur_yx, busy, fill_done
  );
endinterface
`default_nettype wire

// File: rtl/char_buf_fill.sv
`default_nettype none
// ============================================================================
// Module      : char_buf_fill
// Description : Whole-buffer fill engine. Sweeps every in-range cell row-major,
//               one per cycle, presenting a write triple to the storage array.
//               After reset release it starts a clear-to-zero sweep by itself.
//   clk, rst              : clock, async active-high reset
//   fill_start, fill_code : start request and fill value (taken in IDLE only)
//   busy, fill_done       : sweep in progress / one-cycle end pulse
//   fill_we/yx/data       : write triple towards the array
// Revision    : 1.0 - initial release
// ============================================================================
module char_buf_fill
  import char_buf_pkg::*;
#(
  parameter int COLS   = c_def_cols,
  parameter int ROWS   = c_def_rows,
  parameter int CODE_W = c_def_code_w
) (
  input  wire logic                              clk,
  input  wire logic                              rst,
  input  wire logic                              fill_start,
  input  wire logic [CODE_W-1:0]                 fill_code,
  output logic                                   busy,
  output logic                                   fill_done,
  output logic                                   fill_we,
  output logic [addr_w(ROWS)+addr_w(COLS)-1:0]   fill_yx,
  output logic [CODE_W-1:0]                      fill_data
);

  localparam int XW = addr_w(COLS);
  localparam int YW = addr_w(ROWS);
  localparam logic [XW-1:0] c_x_last = XW'(COLS - 1);
  localparam logic [YW-1:0] c_y_last = YW'(ROWS - 1);

  fill_state_t       r_state;
  logic              r_auto_clr;  // pending post-reset clear
  logic              r_busy;
  logic              r_done;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [CODE_W-1:0] r_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_auto_clr <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_code     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_auto_clr || fill_start) begin
            r_state    <= S_FILL;
            r_busy     <= 1'b1;
            r_code     <= r_auto_clr ? '0 : fill_code;
            r_auto_clr <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
          end
        end
        S_FILL: begin
          if (r_x == c_x_last) begin
            r_x <= '0;
            if (r_y == c_y_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_y <= r_y + 1'b1;
            end
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign fill_done = r_done;
  assign fill_we   = r_busy;
  assign fill_yx   = {r_y, r_x};
  assign fill_data = r_code;

endmodule
`default_nettype wire

// File: rtl/char_buf_ram.sv
`default_nettype none
// ============================================================================
// Module      : char_buf_ram
// Description : COLS x ROWS character buffer with a registered read port, a
//               random-access write port, a cursor-stream write port and a
//               whole-buffer fill engine. Write priority: fill > wr > put.
//   clk, rst : clock, async active-high reset
//   bus      : char_buf_ram_if.slave (read, write, put, cursor, fill, status)
// Revision    : 1.0 - initial release
// ============================================================================
module char_buf_ram
  import char_buf_pkg::*;
#(
  parameter int COLS   = c_def_cols,
  parameter int ROWS   = c_def_rows,
  parameter int CODE_W = c_def_code_w
) (
  input  wire logic      clk,
  input  wire logic      rst,
  char_buf_ram_if.slave  bus
);

  localparam int XW    = addr_w(COLS);
  localparam int YW    = addr_w(ROWS);
  localparam int AW    = XW + YW;
  localparam int DEPTH = 1 << AW;
  localparam logic [XW-1:0] c_x_last = XW'(COLS - 1);
  localparam logic [YW-1:0] c_y_last = YW'(ROWS - 1);

  // Storage is deliberately left without reset so it maps onto RAM.
  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [CODE_W-1:0] r_rd;
  logic [XW-1:0]     r_cx;
  logic [YW-1:0]     r_cy;

  logic              w_busy;
  logic              w_fill_we;
  logic [AW-1:0]     w_fill_yx;
  logic [CODE_W-1:0] w_fill_data;

  char_buf_fill #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .CODE_W (CODE_W)
  ) u_fill (
    .clk        (clk),
    .rst        (rst),
    .fill_start (bus.fill_start),
    .fill_code  (bus.fill_code),
    .busy       (w_busy),
    .fill_done  (bus.fill_done),
    .fill_we    (w_fill_we),
    .fill_yx    (w_fill_yx),
    .fill_data  (w_fill_data)
  );

  logic w_rd_ok;
  logic w_wr_in;
  logic w_wr_ok;
  logic w_put_ok;

  assign w_rd_ok = (32'(bus.char_yx[XW-1:0]) < COLS) &&
                   (32'(bus.char_yx[AW-1:XW]) < ROWS);
  assign w_wr_in = (32'(bus.wr_yx[XW-1:0]) < COLS) &&
                   (32'(bus.wr_yx[AW-1:XW]) < ROWS);
  assign w_wr_ok  = bus.wr_en && !w_busy && w_wr_in;
  // Any wr_en request outranks the stream port, even one that gets dropped.
  assign w_put_ok = bus.put_en && !w_busy && !bus.wr_en;

  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [CODE_W-1:0] w_wdata;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (w_fill_we) begin
      w_we    = 1'b1;
      w_waddr = w_fill_yx;
      w_wdata = w_fill_data;
    end else if (w_wr_ok) begin
      w_we    = 1'b1;
      w_waddr = bus.wr_yx;
      w_wdata = bus.wr_code;
    end else if (w_put_ok) begin
      w_we    = 1'b1;
      w_waddr = {r_cy, r_cx};
      w_wdata = bus.put_code;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Read-first: the array read samples the pre-write contents at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd <= '0;
    end else begin
      r_rd <= w_rd_ok ? r_mem[bus.char_yx] : '0;
    end
  end

  // cur_set wins over a same-cycle put advance; the put still writes at the
  // old cursor through the write mux above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (!w_busy) begin
      if (bus.cur_set) begin
        r_cx <= w_wr_in ? bus.wr_yx[XW-1:0]  : '0;
        r_cy <= w_wr_in ? bus.wr_yx[AW-1:XW] : '0;
      end else if (w_put_ok) begin
        if (r_cx == c_x_last) begin
          r_cx <= '0;
          r_cy <= (r_cy == c_y_last) ? '0 : r_cy + 1'b1;
        end else begin
          r_cx <= r_cx + 1'b1;
        end
      end
    end
  end

  assign bus.char_code = r_rd;
  assign bus.cur_yx    = {r_cy, r_cx};
  assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_char_buf_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_char_buf_ram
// Description : Self-checking bench for char_buf_ram. A 16x16 instance and a
//               10x3 instance are checked against array/cursor models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_char_buf_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_s;

  char_buf_ram_if #(.XW(4), .YW(4), .CODE_W(7)) m_if ();
  char_buf_ram_if #(.XW(4), .YW(2), .CODE_W(7)) s_if ();

  char_buf_ram #(.COLS(16), .ROWS(16), .CODE_W(7)) dut (
    .clk (clk), .rst (rst), .bus (m_if.slave)
  );

  char_buf_ram #(.COLS(10), .ROWS(3), .CODE_W(7)) dut_s (
    .clk (clk), .rst (rst_s), .bus (s_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] mdl [256];  // 16x16 contents, index = y*16+x
  int         mcur;       // 16x16 cursor as linear index
  logic [6:0] smdl [30];  // 10x3 contents, index = y*10+x
  int         scur;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_m();
    m_if.char_yx = '0; m_if.wr_en = 0; m_if.wr_yx = '0; m_if.wr_code = '0;
    m_if.put_en = 0; m_if.put_code = '0; m_if.cur_set = 0;
    m_if.fill_start = 0; m_if.fill_code = '0;
  endtask

  task automatic idle_s();
    s_if.char_yx = '0; s_if.wr_en = 0; s_if.wr_yx = '0; s_if.wr_code = '0;
    s_if.put_en = 0; s_if.put_code = '0; s_if.cur_set = 0;
    s_if.fill_start = 0; s_if.fill_code = '0;
  endtask

  task automatic count_busy_m(output int n);
    n = 0;
    while (m_if.busy === 1'b1 && n < 400) begin
      n++;
      tick();
    end
  endtask

  task automatic count_busy_s(output int n);
    n = 0;
    while (s_if.busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  function automatic logic [5:0] s_yx(input int idx);
    return {2'(idx / 10), 4'(idx % 10)};
  endfunction

  // ---------------------------------------------------------------- 16x16
  task automatic test_reset();
    int n;
    rst = 1'b1; rst_s = 1'b1;
    idle_m(); idle_s();
    tick(); tick();
    n_tests++; if (m_if.char_code !== 7'd0) begin n_fail++; $display("FAIL rst_char_code: got %0h want 0", m_if.char_code); end
    n_tests++; if (m_if.cur_yx !== 8'd0) begin n_fail++; $display("FAIL rst_cur_yx: got %0h want 0", m_if.cur_yx); end
    n_tests++; if (m_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", m_if.busy); end
    n_tests++; if (m_if.fill_done !== 1'b0) begin n_fail++; $display("FAIL rst_fill_done: got %0b want 0", m_if.fill_done); end
    rst = 1'b0;
    tick();
    count_busy_m(n);
    n_tests++; if (n != 256) begin n_fail++; $display("FAIL clr_busy_len: got %0d want 256", n); end
    n_tests++; if (m_if.fill_done !== 1'b1) begin n_fail++; $display("FAIL clr_done_pulse: got %0b want 1", m_if.fill_done); end
    tick();
    n_tests++; if (m_if.fill_done !== 1'b0) begin n_fail++; $display("FAIL clr_done_len: got %0b want 0", m_if.fill_done); end
    for (int a = 0; a < 256; a++) begin
      m_if.char_yx = 8'(a);
      tick();
      n_tests++; if (m_if.char_code !== 7'd0) begin n_fail++; $display("FAIL clr_cell %0h: got %0h want 0", a, m_if.char_code); end
    end
    foreach (mdl[i]) mdl[i] = '0;
    mcur = 0;
  endtask

  task automatic test_write_read();
    m_if.wr_en = 1; m_if.wr_yx = 8'h2a; m_if.wr_code = 7'd67; m_if.char_yx = 8'h2a;
    tick();
    m_if.wr_en = 0;
    n_tests++; if (m_if.char_code !== 7'd0) begin n_fail++; $display("FAIL rd_first: got %0d want 0", m_if.char_code); end
    tick();
    n_tests++; if (m_if.char_code !== 7'd67) begin n_fail++; $display("FAIL wr_rd: got %0d want 67", m_if.char_code); end
    mdl[8'h2a] = 7'd67;
  endtask

  task automatic test_cursor();
    m_if.cur_set = 1; m_if.wr_yx = 8'h0f;
    tick();
    m_if.cur_set = 0;
    n_tests++; if (m_if.cur_yx !== 8'h0f) begin n_fail++; $display("FAIL cur_set: got %0h want 0f", m_if.cur_yx); end
    for (int i = 0; i < 3; i++) begin
      m_if.put_en = 1; m_if.put_code = 7'(65 + i);
      tick();
    end
    m_if.put_en = 0;
    n_tests++; if (m_if.cur_yx !== 8'h12) begin n_fail++; $display("FAIL cur_adv: got %0h want 12", m_if.cur_yx); end
    mdl[8'h0f] = 7'd65; mdl[8'h10] = 7'd66; mdl[8'h11] = 7'd67;
    for (int a = 8'h0f; a <= 8'h11; a++) begin
      m_if.char_yx = 8'(a);
      tick();
      n_tests++; if (m_if.char_code !== mdl[a]) begin n_fail++; $display("FAIL put_cell %0h: got %0d want %0d", a, m_if.char_code, mdl[a]); end
    end
    m_if.cur_set = 1; m_if.wr_yx = 8'hff;
    tick();
    m_if.cur_set = 0; m_if.put_en = 1; m_if.put_code = 7'd33;
    tick();
    m_if.put_en = 0;
    n_tests++; if (m_if.cur_yx !== 8'h00) begin n_fail++; $display("FAIL cur_wrap: got %0h want 00", m_if.cur_yx); end
    mdl[8'hff] = 7'd33; mcur = 0;
    m_if.char_yx = 8'hff;
    tick();
    n_tests++; if (m_if.char_code !== 7'd33) begin n_fail++; $display("FAIL put_last: got %0d want 33", m_if.char_code); end
  endtask

  task automatic test_random();
    logic [6:0] exp_rd;
    int old;
    for (int i = 0; i < 300; i++) begin
      m_if.wr_en    = ($urandom_range(0, 3) == 0);
      m_if.put_en   = ($urandom_range(0, 2) == 0);
      m_if.cur_set  = ($urandom_range(0, 9) == 0);
      m_if.wr_yx    = 8'($urandom);
      m_if.wr_code  = 7'($urandom);
      m_if.put_code = 7'($urandom);
      m_if.char_yx  = 8'($urandom);
      exp_rd = mdl[m_if.char_yx];
      old = mcur;
      if (m_if.cur_set) mcur = int'(m_if.wr_yx);
      if (m_if.wr_en) mdl[m_if.wr_yx] = m_if.wr_code;
      else if (m_if.put_en) begin
        mdl[old] = m_if.put_code;
        if (!m_if.cur_set) mcur = (old + 1) % 256;
      end
      tick();
      n_tests++; if (m_if.char_code !== exp_rd) begin n_fail++; $display("FAIL rand_rd #%0d: got %0h want %0h", i, m_if.char_code, exp_rd); end
      n_tests++; if (m_if.cur_yx !== 8'(mcur)) begin n_fail++; $display("FAIL rand_cur #%0d: got %0h want %0h", i, m_if.cur_yx, mcur); end
    end
    idle_m();
  endtask

  task automatic test_fill();
    int n;
    // wr_en alongside the accepted start is performed, then swept over.
    m_if.fill_start = 1; m_if.fill_code = 7'd95;
    m_if.wr_en = 1; m_if.wr_yx = 8'h33; m_if.wr_code = 7'd5;
    tick();
    idle_m();
    n = 0;
    while (m_if.busy === 1'b1 && n < 400) begin
      n++;
      m_if.wr_en = $urandom_range(0, 1); m_if.put_en = $urandom_range(0, 1);
      m_if.cur_set = ($urandom_range(0, 7) == 0);
      m_if.fill_start = ($urandom_range(0, 15) == 0); m_if.fill_code = 7'd12;
      m_if.wr_yx = 8'($urandom); m_if.wr_code = 7'($urandom); m_if.put_code = 7'($urandom);
      tick();
    end
    idle_m();
    n_tests++; if (n != 256) begin n_fail++; $display("FAIL fill_busy_len: got %0d want 256", n); end
    n_tests++; if (m_if.fill_done !== 1'b1) begin n_fail++; $display("FAIL fill_done: got %0b want 1", m_if.fill_done); end
    n_tests++; if (m_if.cur_yx !== 8'(mcur)) begin n_fail++; $display("FAIL fill_cur: got %0h want %0h", m_if.cur_yx, mcur); end
    tick();
    foreach (mdl[i]) mdl[i] = 7'd95;
    for (int a = 0; a < 256; a++) begin
      m_if.char_yx = 8'(a);
      tick();
      n_tests++; if (m_if.char_code !== mdl[a]) begin n_fail++; $display("FAIL fill_cell %0h: got %0d want 95", a, m_if.char_code); end
    end
  endtask

  task automatic test_rst_mid();
    int n;
    m_if.fill_start = 1; m_if.fill_code = 7'd7;
    tick();
    idle_m();
    repeat (100) tick();
    rst = 1'b1;
    #1;
    n_tests++; if (m_if.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b want 0", m_if.busy); end
    n_tests++; if (m_if.cur_yx !== 8'd0) begin n_fail++; $display("FAIL abort_cur: got %0h want 0", m_if.cur_yx); end
    tick();
    rst = 1'b0;
    tick();
    count_busy_m(n);
    n_tests++; if (n != 256) begin n_fail++; $display("FAIL reclr_busy_len: got %0d want 256", n); end
    tick();
    foreach (mdl[i]) mdl[i] = '0;
    mcur = 0;
    for (int a = 0; a < 256; a++) begin
      m_if.char_yx = 8'(a);
      tick();
      n_tests++; if (m_if.char_code !== 7'd0) begin n_fail++; $display("FAIL reclr_cell %0h: got %0d want 0", a, m_if.char_code); end
    end
  endtask

  // ---------------------------------------------------------------- 10x3
  task automatic test_small_reset();
    int n;
    rst_s = 1'b0;
    tick();
    count_busy_s(n);
    n_tests++; if (n != 30) begin n_fail++; $display("FAIL s_clr_len: got %0d want 30", n); end
    n_tests++; if (s_if.fill_done !== 1'b1) begin n_fail++; $display("FAIL s_clr_done: got %0b want 1", s_if.fill_done); end
    tick();
    foreach (smdl[i]) smdl[i] = '0;
    scur = 0;
  endtask

  task automatic test_small_bounds();
    s_if.wr_en = 1; s_if.wr_yx = {2'd1, 4'd12}; s_if.wr_code = 7'd5;
    tick();
    s_if.wr_en = 0; s_if.char_yx = {2'd1, 4'd12};
    tick();
    n_tests++; if (s_if.char_code !== 7'd0) begin n_fail++; $display("FAIL s_oob_read: got %0d want 0", s_if.char_code); end
    s_if.cur_set = 1; s_if.wr_yx = {2'd2, 4'd9};
    tick();
    s_if.cur_set = 0; s_if.put_en = 1; s_if.put_code = 7'd8;
    tick();
    s_if.put_en = 0;
    n_tests++; if (s_if.cur_yx !== 6'd0) begin n_fail++; $display("FAIL s_cur_wrap: got %0h want 0", s_if.cur_yx); end
    smdl[29] = 7'd8;
    s_if.char_yx = {2'd2, 4'd9};
    tick();
    n_tests++; if (s_if.char_code !== 7'd8) begin n_fail++; $display("FAIL s_last_cell: got %0d want 8", s_if.char_code); end
    s_if.put_en = 1; s_if.put_code = 7'd4;
    tick();
    smdl[0] = 7'd4;
    s_if.put_en = 0; s_if.cur_set = 1; s_if.wr_yx = {2'd0, 4'd12};
    tick();
    s_if.cur_set = 0;
    n_tests++; if (s_if.cur_yx !== 6'd0) begin n_fail++; $display("FAIL s_cur_clamp: got %0h want 0", s_if.cur_yx); end
    scur = 0;
  endtask

  task automatic test_small_random();
    logic [6:0] exp_rd;
    int old, rx, ry, wx, wy;
    bit w_in;
    for (int i = 0; i < 200; i++) begin
      s_if.wr_en    = ($urandom_range(0, 3) == 0);
      s_if.put_en   = ($urandom_range(0, 2) == 0);
      s_if.cur_set  = ($urandom_range(0, 9) == 0);
      s_if.wr_yx    = 6'($urandom);
      s_if.wr_code  = 7'($urandom);
      s_if.put_code = 7'($urandom);
      s_if.char_yx  = 6'($urandom);
      rx = int'(s_if.char_yx[3:0]); ry = int'(s_if.char_yx[5:4]);
      wx = int'(s_if.wr_yx[3:0]);   wy = int'(s_if.wr_yx[5:4]);
      w_in = (wx < 10) && (wy < 3);
      exp_rd = (rx < 10 && ry < 3) ? smdl[ry*10 + rx] : 7'd0;
      old = scur;
      if (s_if.cur_set) scur = w_in ? wy*10 + wx : 0;
      if (s_if.wr_en) begin
        if (w_in) smdl[wy*10 + wx] = s_if.wr_code;
      end else if (s_if.put_en) begin
        smdl[old] = s_if.put_code;
        if (!s_if.cur_set) scur = (old + 1) % 30;
      end
      tick();
      n_tests++; if (s_if.char_code !== exp_rd) begin n_fail++; $display("FAIL s_rand_rd #%0d: got %0h want %0h", i, s_if.char_code, exp_rd); end
      n_tests++; if (s_if.cur_yx !== s_yx(scur)) begin n_fail++; $display("FAIL s_rand_cur #%0d: got %0h want %0h", i, s_if.cur_yx, s_yx(scur)); end
    end
    idle_s();
  endtask

  task automatic test_small_fill();
    int n;
    s_if.fill_start = 1; s_if.fill_code = 7'd9;
    tick();
    idle_s();
    count_busy_s(n);
    n_tests++; if (n != 30) begin n_fail++; $display("FAIL s_fill_len: got %0d want 30", n); end
    tick();
    for (int i = 0; i < 30; i++) begin
      s_if.char_yx = s_yx(i);
      tick();
      n_tests++; if (s_if.char_code !== 7'd9) begin n_fail++; $display("FAIL s_fill_cell %0d: got %0d want 9", i, s_if.char_code); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_cursor();
    test_random();
    test_fill();
    test_rst_mid();
    test_small_reset();
    test_small_bounds();
    test_small_random();
    test_small_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
